ysyx_22050710_axi4full_arbiter: RTL and testbench

YSYX_22050710_AXI4FULL_ARBITER -- requirements
Module: ysyx_22050710_axi4full_arbiter

---
 rtl/ysyx_22050710_axi_pkg.sv | 26 ++
 rtl/ysyx_22050710_axi_beat_cnt.sv | 64 ++++++
 rtl/ysyx_22050710_axi4full_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_ysyx_22050710_axi4full_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050710_axi_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_22050710_axi_pkg
// Shared AXI4 definitions for the IFU/LSU arbiter slice: channel field widths,
// response codes and the read-arbiter FSM state encoding.
// -----------------------------------------------------------------------------
package ysyx_22050710_axi_pkg;

  localparam int ID_W    = 4;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  localparam logic [RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

  // Read-path ownership: IDLE arbitrates, OWN_Mx routes the R channel to x.
  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_OWN_M0 = 2'd1,
    RD_OWN_M1 = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ysyx_22050710_axi_beat_cnt.sv
// -----------------------------------------------------------------------------
// ysyx_22050710_axi_beat_cnt
// Tracks the remaining beats of the single outstanding read burst and raises a
// sticky length-error flag when RLAST disagrees with the granted ARLEN.
//
// Ports
//   i_aclk    clock (rising edge)
//   i_rst     synchronous active-high reset
//   i_load    AR handshake: load i_len as the remaining-beat count
//   i_len     ARLEN of the granted request
//   i_beat    R handshake of the current burst
//   i_last    RLAST accompanying i_beat
//   o_len_err sticky beat-count mismatch flag, cleared only by reset
// -----------------------------------------------------------------------------
module ysyx_22050710_axi_beat_cnt
  import ysyx_22050710_axi_pkg::*;
(
  input  logic             i_aclk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_beat,
  input  logic             i_last,
  output logic             o_len_err
);

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (i_load) begin
      cnt_d = i_len;
    end else if (i_beat) begin
      // RLAST must coincide exactly with the beat that finds the count at 0.
      if (i_last ? (cnt_q != '0) : (cnt_q == '0)) begin
        err_d = 1'b1;
      end
      // Saturate so an over-long burst cannot wrap into a bogus count.
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Held low during reset too, not just from the first reset edge onward.
  assign o_len_err = err_q & ~i_rst;

endmodule

// File: rtl/ysyx_22050710_axi4full_arbiter.sv
// -----------------------------------------------------------------------------
// ysyx_22050710_axi4full_arbiter
// Two-master (M0 = IFU read-only, M1 = LSU read/write) to one-slave AXI4-full
// arbiter in front of ysyx_22050710_axi4full_sram_wrap. One read burst is
// outstanding at a time; arbitration and routing are purely combinational.
// M1 write channels pass straight through, independent of the read path.
//
// Ports
//   i_aclk, i_rst         clock, synchronous active-high reset
//   i_m0_ar*/o_m0_r*      IFU read address / read data channels
//   i_m1_ar*/o_m1_r*      LSU read address / read data channels
//   i_m1_aw*/i_m1_w*/o_m1_b*  LSU write channels (forwarded)
//   o_s_*/i_s_*           slave-side AXI4-full channels
//   o_len_err             sticky RLAST/ARLEN mismatch flag
//
// Configuration
//   YSYX_22050710_ARB_RR_EN  defined: round-robin on simultaneous requests.
//                            undefined: fixed priority, M1 wins ties.
// -----------------------------------------------------------------------------
module ysyx_22050710_axi4full_arbiter
  import ysyx_22050710_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  i_aclk,
  input  logic                  i_rst,
  // M0 (IFU) read
  input  logic [ID_W-1:0]       i_m0_arid,
  input  logic [ADDR_WIDTH-1:0] i_m0_araddr,
  input  logic [LEN_W-1:0]      i_m0_arlen,
  input  logic [SIZE_W-1:0]     i_m0_arsize,
  input  logic [BURST_W-1:0]    i_m0_arburst,
  input  logic                  i_m0_arvalid,
  output logic                  o_m0_arready,
  output logic [ID_W-1:0]       o_m0_rid,
  output logic [DATA_WIDTH-1:0] o_m0_rdata,
  output logic [RESP_W-1:0]     o_m0_rresp,
  output logic                  o_m0_rlast,
  output logic                  o_m0_rvalid,
  input  logic                  i_m0_rready,
  // M1 (LSU) read
  input  logic [ID_W-1:0]       i_m1_arid,
  input  logic [ADDR_WIDTH-1:0] i_m1_araddr,
  input  logic [LEN_W-1:0]      i_m1_arlen,
  input  logic [SIZE_W-1:0]     i_m1_arsize,
  input  logic [BURST_W-1:0]    i_m1_arburst,
  input  logic                  i_m1_arvalid,
  output logic                  o_m1_arready,
  output logic [ID_W-1:0]       o_m1_rid,
  output logic [DATA_WIDTH-1:0] o_m1_rdata,
  output logic [RESP_W-1:0]     o_m1_rresp,
  output logic                  o_m1_rlast,
  output logic                  o_m1_rvalid,
  input  logic                  i_m1_rready,
  // M1 (LSU) write
  input  logic [ID_W-1:0]       i_m1_awid,
  input  logic [ADDR_WIDTH-1:0] i_m1_awaddr,
  input  logic [LEN_W-1:0]      i_m1_awlen,
  input  logic [SIZE_W-1:0]     i_m1_awsize,
  input  logic [BURST_W-1:0]    i_m1_awburst,
  input  logic                  i_m1_awvalid,
  output logic                  o_m1_awready,
  input  logic [DATA_WIDTH-1:0] i_m1_wdata,
  input  logic [STRB_WIDTH-1:0] i_m1_wstrb,
  input  logic                  i_m1_wlast,
  input  logic                  i_m1_wvalid,
  output logic                  o_m1_wready,
  output logic [ID_W-1:0]       o_m1_bid,
  output logic [RESP_W-1:0]     o_m1_bresp,
  output logic                  o_m1_bvalid,
  input  logic                  i_m1_bready,
  // Slave read
  output logic [ID_W-1:0]       o_s_arid,
  output logic [ADDR_WIDTH-1:0] o_s_araddr,
  output logic [LEN_W-1:0]      o_s_arlen,
  output logic [SIZE_W-1:0]     o_s_arsize,
  output logic [BURST_W-1:0]    o_s_arburst,
  output logic                  o_s_arvalid,
  input  logic                  i_s_arready,
  input  logic [ID_W-1:0]       i_s_rid,
  input  logic [DATA_WIDTH-1:0] i_s_rdata,
  input  logic [RESP_W-1:0]     i_s_rresp,
  input  logic                  i_s_rlast,
  input  logic                  i_s_rvalid,
  output logic                  o_s_rready,
  // Slave write
  output logic [ID_W-1:0]       o_s_awid,
  output logic [ADDR_WIDTH-1:0] o_s_awaddr,
  output logic [LEN_W-1:0]      o_s_awlen,
  output logic [SIZE_W-1:0]     o_s_awsize,
  output logic [BURST_W-1:0]    o_s_awburst,
  output logic                  o_s_awvalid,
  input  logic                  i_s_awready,
  output logic [DATA_WIDTH-1:0] o_s_wdata,
  output logic [STRB_WIDTH-1:0] o_s_wstrb,
  output logic                  o_s_wlast,
  output logic                  o_s_wvalid,
  input  logic                  i_s_wready,
  input  logic [ID_W-1:0]       i_s_bid,
  input  logic [RESP_W-1:0]     i_s_bresp,
  input  logic                  i_s_bvalid,
  output logic                  o_s_bready,
  // Status
  output logic                  o_len_err
);

  rd_state_e state_q, state_d;
  logic      ar_req;
  logic      grant_m1;
  logic      ar_fire;
  logic      r_fire;

  assign ar_req = i_m0_arvalid | i_m1_arvalid;

`ifdef YSYX_22050710_ARB_RR_EN
  // prefer_m1_q names the master that wins the next tie: the one not granted
  // last. Reset leaves M0 preferred.
  logic prefer_m1_q;

  always_comb grant_m1 = i_m1_arvalid & (~i_m0_arvalid | prefer_m1_q);

  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      prefer_m1_q <= 1'b0;
    end else if (ar_fire) begin
      prefer_m1_q <= ~grant_m1;
    end
  end
`else
  // Fixed priority: the LSU wins whenever it asks.
  assign grant_m1 = i_m1_arvalid;
`endif

  // AR payload follows the winner; only arvalid is gated by the FSM.
  assign o_s_arid    = grant_m1 ? i_m1_arid    : i_m0_arid;
  assign o_s_araddr  = grant_m1 ? i_m1_araddr  : i_m0_araddr;
  assign o_s_arlen   = grant_m1 ? i_m1_arlen   : i_m0_arlen;
  assign o_s_arsize  = grant_m1 ? i_m1_arsize  : i_m0_arsize;
  assign o_s_arburst = grant_m1 ? i_m1_arburst : i_m0_arburst;

  // R payload is broadcast; ownership is expressed solely through rvalid.
  assign o_m0_rid   = i_s_rid;
  assign o_m0_rdata = i_s_rdata;
  assign o_m0_rresp = i_s_rresp;
  assign o_m0_rlast = i_s_rlast;
  assign o_m1_rid   = i_s_rid;
  assign o_m1_rdata = i_s_rdata;
  assign o_m1_rresp = i_s_rresp;
  assign o_m1_rlast = i_s_rlast;

  always_comb begin
    state_d      = state_q;
    o_s_arvalid  = 1'b0;
    o_m0_arready = 1'b0;
    o_m1_arready = 1'b0;
    o_s_rready   = 1'b0;
    o_m0_rvalid  = 1'b0;
    o_m1_rvalid  = 1'b0;
    ar_fire      = 1'b0;
    r_fire       = 1'b0;
    if (!i_rst) begin
      case (state_q)
        RD_IDLE: begin
          o_s_arvalid  = ar_req;
          o_m0_arready = i_s_arready & i_m0_arvalid & ~grant_m1;
          o_m1_arready = i_s_arready & grant_m1;
          ar_fire      = ar_req & i_s_arready;
          if (ar_fire) begin
            state_d = grant_m1 ? RD_OWN_M1 : RD_OWN_M0;
          end
        end
        RD_OWN_M0: begin
          o_s_rready  = i_m0_rready;
          o_m0_rvalid = i_s_rvalid;
          r_fire      = i_s_rvalid & i_m0_rready;
          if (r_fire && i_s_rlast) begin
            state_d = RD_IDLE;
          end
        end
        RD_OWN_M1: begin
          o_s_rready  = i_m1_rready;
          o_m1_rvalid = i_s_rvalid;
          r_fire      = i_s_rvalid & i_m1_rready;
          if (r_fire && i_s_rlast) begin
            state_d = RD_IDLE;
          end
        end
        default: state_d = RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      state_q <= RD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  ysyx_22050710_axi_beat_cnt u_beat_cnt (
    .i_aclk    (i_aclk),
    .i_rst     (i_rst),
    .i_load    (ar_fire),
    .i_len     (o_s_arlen),
    .i_beat    (r_fire),
    .i_last    (i_s_rlast),
    .o_len_err (o_len_err)
  );

  // Write path: straight wires, handshakes forced low while in reset.
  assign o_s_awid     = i_m1_awid;
  assign o_s_awaddr   = i_m1_awaddr;
  assign o_s_awlen    = i_m1_awlen;
  assign o_s_awsize   = i_m1_awsize;
  assign o_s_awburst  = i_m1_awburst;
  assign o_s_awvalid  = i_m1_awvalid & ~i_rst;
  assign o_m1_awready = i_s_awready & ~i_rst;
  assign o_s_wdata    = i_m1_wdata;
  assign o_s_wstrb    = i_m1_wstrb;
  assign o_s_wlast    = i_m1_wlast;
  assign o_s_wvalid   = i_m1_wvalid & ~i_rst;
  assign o_m1_wready  = i_s_wready & ~i_rst;
  assign o_m1_bid     = i_s_bid;
  assign o_m1_bresp   = i_s_bresp;
  assign o_m1_bvalid  = i_s_bvalid & ~i_rst;
  assign o_s_bready   = i_m1_bready & ~i_rst;

endmodule

// File: tb/tb_ysyx_22050710_axi4full_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ysyx_22050710_axi4full_arbiter
// Directed sequence with randomized payloads. The bench plays both masters and
// the slave; expectations come from a transaction-level model: who wins a tie,
// which beats reach whom, and whether RLAST agrees with ARLEN.
// -----------------------------------------------------------------------------
module tb_ysyx_22050710_axi4full_arbiter;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int SW = DW / 8;
`ifdef YSYX_22050710_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic i_rst;
  logic [3:0] i_m0_arid, i_m1_arid, o_m0_rid, o_m1_rid;
  logic [AW-1:0] i_m0_araddr, i_m1_araddr;
  logic [7:0] i_m0_arlen, i_m1_arlen;
  logic [2:0] i_m0_arsize, i_m1_arsize;
  logic [1:0] i_m0_arburst, i_m1_arburst;
  logic i_m0_arvalid, i_m1_arvalid, o_m0_arready, o_m1_arready;
  logic [DW-1:0] o_m0_rdata, o_m1_rdata;
  logic [1:0] o_m0_rresp, o_m1_rresp;
  logic o_m0_rlast, o_m1_rlast, o_m0_rvalid, o_m1_rvalid, i_m0_rready, i_m1_rready;
  logic [3:0] i_m1_awid, o_s_awid, o_m1_bid, i_s_bid;
  logic [AW-1:0] i_m1_awaddr, o_s_awaddr;
  logic [7:0] i_m1_awlen, o_s_awlen;
  logic [2:0] i_m1_awsize, o_s_awsize;
  logic [1:0] i_m1_awburst, o_s_awburst, o_m1_bresp, i_s_bresp;
  logic i_m1_awvalid, o_m1_awready, o_s_awvalid, i_s_awready;
  logic [DW-1:0] i_m1_wdata, o_s_wdata;
  logic [SW-1:0] i_m1_wstrb, o_s_wstrb;
  logic i_m1_wlast, i_m1_wvalid, o_m1_wready, o_s_wlast, o_s_wvalid, i_s_wready;
  logic o_m1_bvalid, i_m1_bready, i_s_bvalid, o_s_bready;
  logic [3:0] o_s_arid, i_s_rid;
  logic [AW-1:0] o_s_araddr;
  logic [7:0] o_s_arlen;
  logic [2:0] o_s_arsize;
  logic [1:0] o_s_arburst, i_s_rresp;
  logic o_s_arvalid, i_s_arready;
  logic [DW-1:0] i_s_rdata;
  logic i_s_rlast, i_s_rvalid, o_s_rready;
  logic o_len_err;

  ysyx_22050710_axi4full_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .i_aclk(clk), .i_rst(i_rst),
    .i_m0_arid(i_m0_arid), .i_m0_araddr(i_m0_araddr), .i_m0_arlen(i_m0_arlen),
    .i_m0_arsize(i_m0_arsize), .i_m0_arburst(i_m0_arburst), .i_m0_arvalid(i_m0_arvalid),
    .o_m0_arready(o_m0_arready), .o_m0_rid(o_m0_rid), .o_m0_rdata(o_m0_rdata),
    .o_m0_rresp(o_m0_rresp), .o_m0_rlast(o_m0_rlast), .o_m0_rvalid(o_m0_rvalid),
    .i_m0_rready(i_m0_rready),
    .i_m1_arid(i_m1_arid), .i_m1_araddr(i_m1_araddr), .i_m1_arlen(i_m1_arlen),
    .i_m1_arsize(i_m1_arsize), .i_m1_arburst(i_m1_arburst), .i_m1_arvalid(i_m1_arvalid),
    .o_m1_arready(o_m1_arready), .o_m1_rid(o_m1_rid), .o_m1_rdata(o_m1_rdata),
    .o_m1_rresp(o_m1_rresp), .o_m1_rlast(o_m1_rlast), .o_m1_rvalid(o_m1_rvalid),
    .i_m1_rready(i_m1_rready),
    .i_m1_awid(i_m1_awid), .i_m1_awaddr(i_m1_awaddr), .i_m1_awlen(i_m1_awlen),
    .i_m1_awsize(i_m1_awsize), .i_m1_awburst(i_m1_awburst), .i_m1_awvalid(i_m1_awvalid),
    .o_m1_awready(o_m1_awready), .i_m1_wdata(i_m1_wdata), .i_m1_wstrb(i_m1_wstrb),
    .i_m1_wlast(i_m1_wlast), .i_m1_wvalid(i_m1_wvalid), .o_m1_wready(o_m1_wready),
    .o_m1_bid(o_m1_bid), .o_m1_bresp(o_m1_bresp), .o_m1_bvalid(o_m1_bvalid),
    .i_m1_bready(i_m1_bready),
    .o_s_arid(o_s_arid), .o_s_araddr(o_s_araddr), .o_s_arlen(o_s_arlen),
    .o_s_arsize(o_s_arsize), .o_s_arburst(o_s_arburst), .o_s_arvalid(o_s_arvalid),
    .i_s_arready(i_s_arready), .i_s_rid(i_s_rid), .i_s_rdata(i_s_rdata),
    .i_s_rresp(i_s_rresp), .i_s_rlast(i_s_rlast), .i_s_rvalid(i_s_rvalid),
    .o_s_rready(o_s_rready),
    .o_s_awid(o_s_awid), .o_s_awaddr(o_s_awaddr), .o_s_awlen(o_s_awlen),
    .o_s_awsize(o_s_awsize), .o_s_awburst(o_s_awburst), .o_s_awvalid(o_s_awvalid),
    .i_s_awready(i_s_awready), .o_s_wdata(o_s_wdata), .o_s_wstrb(o_s_wstrb),
    .o_s_wlast(o_s_wlast), .o_s_wvalid(o_s_wvalid), .i_s_wready(i_s_wready),
    .i_s_bid(i_s_bid), .i_s_bresp(i_s_bresp), .i_s_bvalid(i_s_bvalid),
    .o_s_bready(o_s_bready),
    .o_len_err(o_len_err)
  );

  always #5 clk = ~clk;

  // Scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model state
  bit         pend [2];
  logic [31:0] m_addr [2];
  logic [7:0]  m_len [2];
  logic [8:0]  m_ctl [2];   // {id, size, burst}
  int          last_grant;  // 1 after reset: M0 is preferred on the first tie
  bit          err_model;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_winner();
    if (pend[0] && !pend[1]) return 0;
    if (pend[1] && !pend[0]) return 1;
    return (RR_MODE && last_grant == 1) ? 0 : 1;
  endfunction

  task automatic req(input int m, input logic [31:0] a, input logic [7:0] l);
    pend[m]   = 1'b1;
    m_addr[m] = a;
    m_len[m]  = l;
    m_ctl[m]  = 9'($urandom);
    if (m == 0) begin
      i_m0_arvalid = 1'b1; i_m0_araddr = a; i_m0_arlen = l;
      {i_m0_arid, i_m0_arsize, i_m0_arburst} = m_ctl[0];
    end else begin
      i_m1_arvalid = 1'b1; i_m1_araddr = a; i_m1_arlen = l;
      {i_m1_arid, i_m1_arsize, i_m1_arburst} = m_ctl[1];
    end
  endtask

  task automatic drive_writes();
    i_m1_awid = 4'($urandom); i_m1_awaddr = $urandom; i_m1_awlen = 8'($urandom);
    i_m1_awsize = 3'($urandom); i_m1_awburst = 2'($urandom); i_m1_awvalid = 1'($urandom);
    i_m1_wdata = {$urandom, $urandom}; i_m1_wstrb = 8'($urandom);
    i_m1_wlast = 1'($urandom); i_m1_wvalid = 1'($urandom); i_m1_bready = 1'($urandom);
    i_s_awready = 1'($urandom); i_s_wready = 1'($urandom); i_s_bid = 4'($urandom);
    i_s_bresp = 2'($urandom); i_s_bvalid = 1'($urandom);
  endtask

  task automatic check_writes();
    check("aw_addr", 64'({o_s_awvalid, o_s_awaddr}), 64'({i_m1_awvalid, i_m1_awaddr}));
    check("aw_ctl", 64'({o_s_awid, o_s_awlen, o_s_awsize, o_s_awburst}),
          64'({i_m1_awid, i_m1_awlen, i_m1_awsize, i_m1_awburst}));
    check("w_data", o_s_wdata, i_m1_wdata);
    check("w_ctl", 64'({o_s_wstrb, o_s_wlast, o_s_wvalid}), 64'({i_m1_wstrb, i_m1_wlast, i_m1_wvalid}));
    check("wr_hs", 64'({o_m1_awready, o_m1_wready, o_m1_bid, o_m1_bresp, o_m1_bvalid, o_s_bready}),
          64'({i_s_awready, i_s_wready, i_s_bid, i_s_bresp, i_s_bvalid, i_m1_bready}));
  endtask

  task automatic reset_pulse();
    i_rst = 1'b1;
    i_m0_arvalid = 1'b1; i_m1_arvalid = 1'b1; i_s_arready = 1'b1; i_s_rvalid = 1'b1;
    i_m0_rready = 1'b1; i_m1_rready = 1'b1; i_m1_awvalid = 1'b1; i_s_awready = 1'b1;
    i_m1_wvalid = 1'b1; i_s_wready = 1'b1; i_s_bvalid = 1'b1; i_m1_bready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("rst_valids", 64'({o_s_arvalid, o_m0_rvalid, o_m1_rvalid, o_s_awvalid, o_s_wvalid, o_m1_bvalid}), 64'd0);
      check("rst_readies", 64'({o_m0_arready, o_m1_arready, o_s_rready, o_m1_awready, o_m1_wready, o_s_bready}), 64'd0);
      check("rst_len_err", 64'(o_len_err), 64'd0);
      tick();
    end
    i_rst = 1'b0;
    i_m0_arvalid = 1'b0; i_m1_arvalid = 1'b0; i_s_arready = 1'b0; i_s_rvalid = 1'b0;
    i_m0_rready = 1'b0; i_m1_rready = 1'b0; i_m1_awvalid = 1'b0; i_s_awready = 1'b0;
    i_m1_wvalid = 1'b0; i_s_wready = 1'b0; i_s_bvalid = 1'b0; i_m1_bready = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0; err_model = 1'b0; last_grant = 1;
    #1;
    check("post_rst_arvalid", 64'(o_s_arvalid), 64'd0);
    check("post_rst_len_err", 64'(o_len_err), 64'd0);
    tick();
  endtask

  // Offer pending requests to the slave until the AR handshake happens.
  task automatic arbitrate(output int w);
    bit fired = 1'b0;
    w = model_winner();
    for (int t = 0; t < 8 && !fired; t++) begin
      i_s_arready = (t >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      check("s_arvalid", 64'(o_s_arvalid), 64'd1);
      check("s_araddr", 64'(o_s_araddr), 64'(m_addr[w]));
      check("s_arlen", 64'(o_s_arlen), 64'(m_len[w]));
      check("s_arctl", 64'({o_s_arid, o_s_arsize, o_s_arburst}), 64'(m_ctl[w]));
      check("m0_arready", 64'(o_m0_arready), 64'(w == 0 && i_s_arready));
      check("m1_arready", 64'(o_m1_arready), 64'(w == 1 && i_s_arready));
      fired = i_s_arready;
      tick();
    end
    pend[w] = 1'b0;
    last_grant = w;
    if (w == 0) i_m0_arvalid = 1'b0; else i_m1_arvalid = 1'b0;
    i_s_arready = 1'b0;
  endtask

  // Slave returns beats until it raises RLAST at index last_at; the owner's
  // RREADY toggles every cycle. abort_at >= 0 pulses reset before that beat.
  task automatic burst(input int w, input int len, input int last_at, input int abort_at);
    int beat = 0;
    bit done = 1'b0;
    bit rr;
    logic [63:0] d;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (beat == abort_at) begin
        reset_pulse();
        return;
      end
      rr = (cyc % 2 == 0);
      d = {$urandom, $urandom};
      i_s_rvalid = ($urandom_range(0, 3) != 0);
      i_s_rdata = d; i_s_rid = 4'($urandom); i_s_rresp = 2'($urandom);
      i_s_rlast = (beat == last_at);
      i_m0_rready = (w == 0) ? rr : 1'($urandom_range(0, 1));
      i_m1_rready = (w == 1) ? rr : 1'($urandom_range(0, 1));
      drive_writes();
      #1;
      check("s_arvalid_busy", 64'(o_s_arvalid), 64'd0);
      check("own_rvalid", 64'(w == 0 ? o_m0_rvalid : o_m1_rvalid), 64'(i_s_rvalid));
      check("other_rvalid", 64'(w == 0 ? o_m1_rvalid : o_m0_rvalid), 64'd0);
      check("s_rready", 64'(o_s_rready), 64'(rr));
      check("r_ctl", 64'(w == 0 ? {o_m0_rid, o_m0_rresp, o_m0_rlast} : {o_m1_rid, o_m1_rresp, o_m1_rlast}),
            64'({i_s_rid, i_s_rresp, beat == last_at}));
      check("r_data", w == 0 ? o_m0_rdata : o_m1_rdata, d);
      check("len_err", 64'(o_len_err), 64'(err_model));
      check_writes();
      if (i_s_rvalid && rr) begin
        if ((beat == last_at) != (beat == len)) err_model = 1'b1;
        if (beat == last_at) done = 1'b1;
        beat++;
      end
      tick();
    end
    check("burst_done", 64'(done), 64'd1);
    // Back in IDLE: a stale slave rvalid must reach nobody.
    i_s_rvalid = 1'b1; i_s_rlast = 1'b1; i_m0_rready = 1'b1; i_m1_rready = 1'b1;
    #1;
    check("idle_m0_rvalid", 64'(o_m0_rvalid), 64'd0);
    check("idle_m1_rvalid", 64'(o_m1_rvalid), 64'd0);
    check("idle_s_rready", 64'(o_s_rready), 64'd0);
    check("idle_arvalid", 64'(o_s_arvalid), 64'(pend[0] || pend[1]));
    check("idle_len_err", 64'(o_len_err), 64'(err_model));
    i_s_rvalid = 1'b0; i_s_rlast = 1'b0; i_m0_rready = 1'b0; i_m1_rready = 1'b0;
    tick();
  endtask

  task automatic drain();
    int w;
    for (int k = 0; k < 2; k++) begin
      if (pend[0] || pend[1]) begin
        arbitrate(w);
        burst(w, int'(m_len[w]), int'(m_len[w]), -1);
      end
    end
  endtask

  initial begin
    int w;
    {i_m0_arid, i_m0_araddr, i_m0_arlen, i_m0_arsize, i_m0_arburst, i_m0_rready} = '0;
    {i_m1_arid, i_m1_araddr, i_m1_arlen, i_m1_arsize, i_m1_arburst, i_m1_rready} = '0;
    {i_s_rid, i_s_rdata, i_s_rresp, i_s_rlast} = '0;
    {i_m1_awid, i_m1_awaddr, i_m1_awlen, i_m1_awsize, i_m1_awburst, i_m1_wdata, i_m1_wstrb, i_m1_wlast} = '0;
    {i_s_bid, i_s_bresp} = '0;
    pend[0] = 1'b0; pend[1] = 1'b0; last_grant = 1; err_model = 1'b0;

    // Reset state with every input handshake asserted
    reset_pulse();

    // Single-beat IFU read
    req(0, 32'h8000_0000, 8'd0);
    arbitrate(w);
    burst(w, 0, 0, -1);

    // Simultaneous requests; the loser is served after the winner's RLAST
    req(0, 32'h8000_0100, 8'd1);
    req(1, 32'h8000_0200, 8'd1);
    arbitrate(w);
    burst(w, int'(m_len[w]), int'(m_len[w]), -1);
    arbitrate(w);
    burst(w, int'(m_len[w]), int'(m_len[w]), -1);

    // Four back-to-back ties (both masters re-request immediately)
    for (int i = 0; i < 4; i++) begin
      if (!pend[0]) req(0, $urandom, 8'($urandom_range(0, 2)));
      if (!pend[1]) req(1, $urandom, 8'($urandom_range(0, 2)));
      arbitrate(w);
      burst(w, int'(m_len[w]), int'(m_len[w]), -1);
    end
    drain();

    // LSU 4-beat burst under toggling RREADY
    req(1, 32'h8000_1000, 8'd3);
    arbitrate(w);
    burst(w, 3, 3, -1);

    // Random mix of requesters, addresses and lengths
    for (int i = 0; i < 6; i++) begin
      int r = $urandom_range(1, 3);
      if (r[0]) req(0, $urandom, 8'($urandom_range(0, 3)));
      if (r[1]) req(1, $urandom, 8'($urandom_range(0, 3)));
      drain();
    end

    // Early RLAST on beat 2 of a 4-beat burst; flag must stick afterwards
    req(1, 32'h8000_2000, 8'd3);
    arbitrate(w);
    burst(w, 3, 1, -1);
    req(0, 32'h8000_3000, 8'd1);
    arbitrate(w);
    burst(w, 1, 1, -1);

    // Reset during beat 2, then a clean IFU read
    req(0, 32'h8000_4000, 8'd3);
    arbitrate(w);
    burst(w, 3, 3, 1);
    req(0, 32'h8000_4010, 8'd1);
    arbitrate(w);
    burst(w, 1, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
